pulse_handshake_tx: RTL and testbench
=====================================

PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 4, width of the pending-pulse counter; MAX = 2^CNT_W-1.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_pulse, input, 1 bit: event request, one event per high cycle.
REQ-005 The block SHALL have port i_ack_toggle, input, 1 bit: acknowledge toggle from the receiving domain, asynchronous to i_clk.
REQ-006 The block SHALL have port i_ovf_clr, input, 1 bit: synchronous clear of o_overflow.
REQ-007 The block SHALL have port o_req_toggle, output, 1 bit: request toggle, one level change per transferred event.
REQ-008 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when a transfer is acknowledged.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high while a transfer is outstanding or events are pending.
REQ-010 The block SHALL have port o_pending, output, CNT_W bits: count of queued, not yet launched events.
REQ-011 The block SHALL have port o_overflow, output, 1 bit: sticky flag, set when an event is dropped.

Function
REQ-012 i_ack_toggle SHALL pass through a two-flop synchronizer (ack_s1, ack_s2) before any use; no other logic SHALL sample i_ack_toggle directly.
REQ-013 The FSM SHALL have exactly two states, IDLE and WAIT_ACK.
REQ-014 launch SHALL be true iff state==IDLE and (o_pending!=0 or i_pulse==1).
REQ-015 On launch, the block SHALL invert o_req_toggle at the same edge and move to WAIT_ACK; latency from i_pulse (IDLE, pending 0) to the o_req_toggle change SHALL be 1 clock.
REQ-016 In WAIT_ACK, when ack_s2 == o_req_toggle, the block SHALL assert o_done for exactly one cycle and return to IDLE; otherwise it SHALL remain in WAIT_ACK indefinitely.
REQ-017 A launch SHALL NOT occur in the cycle o_done is asserted; the earliest next launch is the cycle after the return to IDLE.
REQ-018 ack_s2 changes while in IDLE SHALL be ignored.
REQ-019 o_pending SHALL update each edge as o_pending + i_pulse - launch, where a launch with o_pending==0 consumes the same-cycle i_pulse directly, leaving o_pending unchanged.
REQ-020 If o_pending==MAX, i_pulse==1 and no launch occurs, the event SHALL be dropped, o_pending SHALL stay MAX, and o_overflow SHALL be set at that edge.
REQ-021 If o_pending==MAX, i_pulse==1 and a launch occurs, o_pending SHALL stay MAX with no drop.
REQ-022 o_overflow SHALL clear on i_ovf_clr==1 unless a drop occurs in the same cycle, in which case set SHALL win.
REQ-023 o_busy SHALL equal (state==WAIT_ACK) or (o_pending!=0), decoded from registers only.
REQ-024 Events SHALL be delivered in arrival order, exactly once each, with no merging of back-to-back pulses.

Reset
REQ-025 While i_rst_n==0, the block SHALL immediately force state=IDLE, o_req_toggle=0, ack_s1=ack_s2=0, o_pending=0, o_done=0 and o_overflow=0; o_busy SHALL therefore read 0.
REQ-026 Reset mid-transfer SHALL discard the outstanding event and all pending events; the receiving end SHALL be reset concurrently so that its ack toggle returns to 0.
REQ-027 After reset release, the first launch SHALL be possible on the first rising edge at which i_rst_n==1.

Verification (CNT_W=2, MAX=3; the bench models the receiver by returning o_req_toggle to i_ack_toggle after a programmable delay D)
REQ-028 Single pulse, D=5: i_pulse is high for 1 cycle -> o_req_toggle goes 0->1 one clock later; o_done pulses once 2-3 clocks after i_ack_toggle rises; o_busy returns to 0.
REQ-029 Burst: i_pulse is high for 4 consecutive cycles, D=10 -> o_pending reaches 3 and o_overflow stays 0; exactly 4 o_req_toggle transitions and 4 o_done pulses occur; final o_req_toggle=0.
REQ-030 Overflow: i_pulse is high for 6 cycles, D=50 -> 1 event launched, 3 pending, 2 dropped; o_overflow=1; 4 o_done pulses total; then i_ovf_clr pulse -> o_overflow=0.
REQ-031 Reset in WAIT_ACK with o_pending=2 -> all outputs are 0 immediately; no o_done appears after reset release without a new i_pulse.
REQ-032 Spurious i_ack_toggle flip while IDLE -> no o_done and no state change; random D in 0..20 with random i_pulse, checked against a scoreboard count, yields launched + dropped == total pulses.

Source files
------------

// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - event queue that ships pulses over a toggle request/ack handshake
module pulse_handshake_tx #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pulse,
   input  logic             i_ack_toggle,
   input  logic             i_ovf_clr,
   output logic             o_req_toggle,
   output logic             o_done,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pending,
   output logic             o_overflow
);

   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       WAIT_ACK = 1'b1;
   localparam logic [CNT_W-1:0] MAX      = {CNT_W{1'b1}};

   logic [0:0]       state;
   logic             ack_s1;
   logic             ack_s2;
   logic             launch;
   logic             ack_seen;
   logic             drop;
   logic [CNT_W-1:0] pending_nxt;

   // The ack toggle comes from another clock domain; only ack_s2 is used below.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= i_ack_toggle;
         ack_s2 <= ack_s1;
      end
   end

   assign ack_seen = (state == WAIT_ACK) && (ack_s2 == o_req_toggle);
   assign launch   = (state == IDLE) && ((o_pending != '0) || i_pulse);
   assign drop     = i_pulse && !launch && (o_pending == MAX);

   // A launch from an empty queue consumes the same-cycle pulse directly.
   always_comb begin
      pending_nxt = o_pending;
      if (i_pulse && !launch && !drop) begin
         pending_nxt = o_pending + 1'b1;
      end else if (!i_pulse && launch) begin
         pending_nxt = o_pending - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         o_req_toggle <= 1'b0;
         o_pending    <= '0;
      end else begin
         o_pending <= pending_nxt;
         case (state)
            IDLE: begin
               if (launch) begin
                  state        <= WAIT_ACK;
                  o_req_toggle <= ~o_req_toggle;
               end
            end
            WAIT_ACK: begin
               if (ack_seen) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Set wins over a simultaneous clear so a drop is never hidden.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overflow <= 1'b0;
      end else if (drop) begin
         o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
         o_overflow <= 1'b0;
      end
   end

   // Done is decoded in WAIT_ACK, so it can never coincide with a launch.
   assign o_done = ack_seen;
   assign o_busy = (state == WAIT_ACK) || (o_pending != '0);

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb/tb_pulse_handshake_tx.sv - scoreboard bench for pulse_handshake_tx with a delayed-ack receiver model
module tb_pulse_handshake_tx;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_pulse;
   logic       i_ack_toggle;
   logic       i_ovf_clr;
   logic       o_req_toggle;
   logic       o_done;
   logic       o_busy;
   logic [1:0] o_pending;
   logic       o_overflow;

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   rx_delay = 5;
   int   rx_cnt = 0;
   bit   rx_en = 1'b1;
   bit   spur_req = 1'b0;
   bit   rand_mode = 1'b0;
   logic rand_par = 1'b0;
   logic exp_tog = 1'b0;
   logic sb[$];
   int   done_cnt = 0;
   int   launches = 0;
   int   pend_max = 0;
   int   ack_chg_cyc = 0;
   logic prev_req = 1'b0;
   logic prev_ack = 1'b0;

   pulse_handshake_tx #(.CNT_W(2)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_pulse      (i_pulse),
      .i_ack_toggle (i_ack_toggle),
      .i_ovf_clr    (i_ovf_clr),
      .o_req_toggle (o_req_toggle),
      .o_done       (o_done),
      .o_busy       (o_busy),
      .o_pending    (o_pending),
      .o_overflow   (o_overflow)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic push_exp();
      exp_tog = ~exp_tog;
      sb.push_back(exp_tog);
   endtask

   task automatic reset_dut();
      i_rst_n   = 1'b0;
      i_pulse   = 1'b0;
      i_ovf_clr = 1'b0;
      sb.delete();
      exp_tog  = 1'b0;
      rand_par = 1'b0;
      tick(2);
      i_rst_n = 1'b1;
   endtask

   task automatic pulse_n(input int n);
      for (int i = 0; i < n; i++) begin
         i_pulse = 1'b1;
         tick(1);
      end
      i_pulse = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((o_busy || (o_req_toggle != i_ack_toggle)) && n < budget) begin
         tick(1);
         n++;
      end
      chk(name, int'(n < budget), 1);
      tick(3);
   endtask

   // Receiver model: echoes o_req_toggle back on the ack after rx_delay cycles.
   initial begin
      i_ack_toggle = 1'b0;
      forever begin
         @(posedge i_clk);
         #2;
         if (!i_rst_n) begin
            i_ack_toggle = 1'b0;
            rx_cnt       = 0;
         end else if (!rx_en) begin
            if (spur_req) begin
               i_ack_toggle = ~i_ack_toggle;
               spur_req     = 1'b0;
            end
         end else if (o_req_toggle != i_ack_toggle) begin
            if (rx_cnt >= rx_delay) begin
               i_ack_toggle = o_req_toggle;
               rx_cnt       = 0;
            end else begin
               rx_cnt++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         cyc++;
      end
   end

   // Monitor: pops one expected toggle value per o_done.
   initial begin
      int   lat;
      logic e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
         end else begin
            if (o_req_toggle != prev_req) launches++;
            prev_req = o_req_toggle;
            if (i_ack_toggle != prev_ack) ack_chg_cyc = cyc;
            prev_ack = i_ack_toggle;
            if (int'(o_pending) > pend_max) pend_max = int'(o_pending);
            if (o_done) begin
               done_cnt++;
               lat = cyc - ack_chg_cyc;
               chk("done_latency_2_to_3", int'(lat >= 2 && lat <= 3), 1);
               if (rand_mode) begin
                  rand_par = ~rand_par;
                  chk("rand_done_toggle", int'(o_req_toggle), int'(rand_par));
               end else if (sb.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("sb_done_toggle", int'(o_req_toggle), int'(e));
               end
            end
         end
      end
   end

   initial begin
      int d0;
      int l0;
      int tot;
      int launched;
      logic r0;

      i_rst_n   = 1'b0;
      i_pulse   = 1'b0;
      i_ovf_clr = 1'b0;
      tick(2);
      chk("reset_req", int'(o_req_toggle), 0);
      chk("reset_done", int'(o_done), 0);
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_pending", int'(o_pending), 0);
      chk("reset_overflow", int'(o_overflow), 0);
      i_rst_n = 1'b1;
      tick(2);

      // Single pulse, D=5
      rx_delay = 5;
      d0 = done_cnt;
      push_exp();
      chk("single_req_before", int'(o_req_toggle), 0);
      pulse_n(1);
      chk("single_req_after_1clk", int'(o_req_toggle), 1);
      chk("single_busy", int'(o_busy), 1);
      drain("single_drain", 100);
      chk("single_done_count", done_cnt - d0, 1);
      chk("single_busy_end", int'(o_busy), 0);
      chk("single_sb_empty", sb.size(), 0);

      // Burst of 4, D=10
      reset_dut();
      rx_delay = 10;
      pend_max = 0;
      d0 = done_cnt;
      l0 = launches;
      for (int i = 0; i < 4; i++) push_exp();
      pulse_n(4);
      chk("burst_pending_after", int'(o_pending), 3);
      drain("burst_drain", 300);
      chk("burst_pend_max", pend_max, 3);
      chk("burst_overflow", int'(o_overflow), 0);
      chk("burst_launches", launches - l0, 4);
      chk("burst_done_count", done_cnt - d0, 4);
      chk("burst_final_req", int'(o_req_toggle), 0);
      chk("burst_sb_empty", sb.size(), 0);

      // Overflow: 6 pulses, D=50; clear on the last (dropping) cycle loses to set
      reset_dut();
      rx_delay = 50;
      d0 = done_cnt;
      l0 = launches;
      for (int i = 0; i < 4; i++) push_exp();
      for (int i = 0; i < 6; i++) begin
         i_pulse   = 1'b1;
         i_ovf_clr = (i == 5);
         tick(1);
      end
      i_pulse   = 1'b0;
      i_ovf_clr = 1'b0;
      chk("ovf_pending", int'(o_pending), 3);
      chk("ovf_set_wins_over_clr", int'(o_overflow), 1);
      chk("ovf_launched_so_far", launches - l0, 1);
      drain("ovf_drain", 600);
      chk("ovf_done_count", done_cnt - d0, 4);
      chk("ovf_sticky", int'(o_overflow), 1);
      i_ovf_clr = 1'b1;
      tick(1);
      i_ovf_clr = 1'b0;
      chk("ovf_cleared", int'(o_overflow), 0);

      // Reset while waiting for ack with 2 pending
      reset_dut();
      rx_delay = 50;
      pulse_n(3);
      chk("rst_mid_pending", int'(o_pending), 2);
      chk("rst_mid_busy", int'(o_busy), 1);
      i_rst_n = 1'b0;
      #1;
      chk("rst_mid_req", int'(o_req_toggle), 0);
      chk("rst_mid_done", int'(o_done), 0);
      chk("rst_mid_busy0", int'(o_busy), 0);
      chk("rst_mid_pending0", int'(o_pending), 0);
      chk("rst_mid_overflow", int'(o_overflow), 0);
      sb.delete();
      exp_tog = 1'b0;
      tick(3);
      d0 = done_cnt;
      i_rst_n = 1'b1;
      tick(80);
      chk("rst_no_done_after", done_cnt - d0, 0);
      chk("rst_req_stays", int'(o_req_toggle), 0);

      // Launch on the very first edge after reset release
      rx_delay = 3;
      i_rst_n = 1'b0;
      tick(2);
      sb.delete();
      exp_tog = 1'b0;
      push_exp();
      i_pulse = 1'b1;
      i_rst_n = 1'b1;
      tick(1);
      i_pulse = 1'b0;
      chk("first_edge_launch", int'(o_req_toggle), 1);
      drain("first_edge_drain", 100);
      chk("first_edge_sb_empty", sb.size(), 0);

      // Spurious ack flips while idle
      rx_en = 1'b0;
      d0 = done_cnt;
      r0 = o_req_toggle;
      spur_req = 1'b1;
      tick(8);
      chk("spur_no_done", done_cnt - d0, 0);
      chk("spur_busy", int'(o_busy), 0);
      chk("spur_req_same", int'(o_req_toggle), int'(r0));
      spur_req = 1'b1;
      tick(8);
      chk("spur_no_done2", done_cnt - d0, 0);
      rx_en = 1'b1;

      // Random pulses with random receiver delay
      reset_dut();
      rand_mode = 1'b1;
      for (int t = 0; t < 4; t++) begin
         rx_delay = $urandom_range(0, 20);
         tot = 0;
         l0 = launches;
         d0 = done_cnt;
         for (int c = 0; c < 40; c++) begin
            i_pulse = ($urandom_range(0, 2) == 0);
            tot += int'(i_pulse);
            tick(1);
         end
         i_pulse = 1'b0;
         drain("rand_drain", 2000);
         launched = launches - l0;
         chk("rand_done_eq_launched", done_cnt - d0, launched);
         chk("rand_launched_le_total", int'(launched <= tot), 1);
         chk("rand_overflow_iff_dropped", int'(o_overflow), int'(launched < tot));
         i_ovf_clr = 1'b1;
         tick(1);
         i_ovf_clr = 1'b0;
      end
      rand_mode = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
